// File: rtl/twi_addr_gen.sv
// Twiddle address sequencer for the radix-16 FFT.
// Walks every stage s and group index j, emitting one registered word per
// cycle: memory address, bank number and twiddle base exponent.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_IDLE | waiting for start; j/s cleared when start is taken
//  ST_RUN  | emitting one word per unstalled cycle, j advancing
//  ST_GAP  | PIPE_GAP idle cycles between stages (stall is ignored here)
//  ST_DONE | one cycle that raises done, then back to idle
module twi_addr_gen #(
    parameter int A_WIDTH   = 9,
    parameter int S_WIDTH   = 2,
    parameter int NUM_STAGE = 4,
    parameter int PIPE_GAP  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    output logic               busy,
    output logic               valid,
    output logic               last,
    output logic               done,
    output logic [S_WIDTH-1:0] stage_out,
    output logic [A_WIDTH-1:0] MA_out,
    output logic               BN_out,
    output logic [A_WIDTH:0]   tw_exp
);

    localparam int JW = A_WIDTH + 1;
    localparam int GW = (PIPE_GAP > 1) ? $clog2(PIPE_GAP) : 1;
    localparam logic [JW-1:0]      J_MAX    = '1;
    localparam logic [S_WIDTH-1:0] S_LAST   = S_WIDTH'(NUM_STAGE - 1);
    // Gap timer is a down-counter that leaves GAP on its zero terminal count.
    localparam logic [GW-1:0]      GAP_LOAD = GW'((PIPE_GAP > 0) ? PIPE_GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [JW-1:0]      j_cnt, j_nx;
    logic [S_WIDTH-1:0] s_cnt, s_nx;
    logic [GW-1:0]      gap_cnt, gap_nx;

    logic               busy_nx, valid_nx, last_nx, done_nx, bn_nx;
    logic [S_WIDTH-1:0] stage_nx;
    logic [A_WIDTH-1:0] ma_nx;
    logic [A_WIDTH:0]   tw_nx;

    // Next-state, counter and output-word computation; every output is registered below.
    always_comb begin
        state_nx = state;
        j_nx     = j_cnt;
        s_nx     = s_cnt;
        gap_nx   = gap_cnt;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        done_nx  = 1'b0;
        stage_nx = stage_out;
        ma_nx    = MA_out;
        bn_nx    = BN_out;
        tw_nx    = tw_exp;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                    j_nx     = '0;
                    s_nx     = '0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    valid_nx = 1'b1;
                    stage_nx = s_cnt;
                    ma_nx    = j_cnt[JW-1:1];
                    bn_nx    = ^j_cnt;
                    // Bits shifted past the top are the exponent's modulo wrap.
                    tw_nx    = j_cnt << {s_cnt, 2'b00};
                    j_nx     = j_cnt + JW'(1);
                    if (j_cnt == J_MAX) begin
                        last_nx = 1'b1;
                        if (s_cnt == S_LAST) begin
                            state_nx = ST_DONE;
                        end else if (PIPE_GAP == 0) begin
                            s_nx = s_cnt + S_WIDTH'(1);
                            j_nx = '0;
                        end else begin
                            state_nx = ST_GAP;
                            gap_nx   = GAP_LOAD;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = ST_RUN;
                    s_nx     = s_cnt + S_WIDTH'(1);
                    j_nx     = '0;
                end else begin
                    gap_nx = gap_cnt - GW'(1);
                end
            end
            ST_DONE: begin
                done_nx  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // busy stays high through the final word so it drops together with done.
        busy_nx = (state_nx != ST_IDLE);
    end

    // State, counters and output word registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            j_cnt     <= '0;
            s_cnt     <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
            stage_out <= '0;
            MA_out    <= '0;
            BN_out    <= 1'b0;
            tw_exp    <= '0;
        end else begin
            state     <= state_nx;
            j_cnt     <= j_nx;
            s_cnt     <= s_nx;
            gap_cnt   <= gap_nx;
            busy      <= busy_nx;
            valid     <= valid_nx;
            last      <= last_nx;
            done      <= done_nx;
            stage_out <= stage_nx;
            MA_out    <= ma_nx;
            BN_out    <= bn_nx;
            tw_exp    <= tw_nx;
        end
    end

endmodule

// File: tb/tb_twi_addr_gen.sv
// Bench for twi_addr_gen: a word-sequence model checks every emitted word of
// the default build, directed runs cover latency, gaps, stall, ignored
// starts, async reset and a back-to-back (no gap) build.
module tb_twi_addr_gen;
    localparam int AW = 9;
    localparam int SW = 2;
    localparam int NS = 4;
    localparam int PG = 5;
    localparam int JN = 1024;

    logic clk = 1'b0;
    logic rst_n, start, stall;
    logic busy, valid, last, done, bn;
    logic [SW-1:0] stage;
    logic [AW-1:0] ma;
    logic [AW:0]   tw;

    logic rst_b, start_b, stall_b;
    logic busy_b, valid_b, last_b, done_b, bn_b;
    logic [SW-1:0] stage_b;
    logic [AW-1:0] ma_b;
    logic [AW:0]   tw_b;

    int checks = 0;
    int errors = 0;
    int exp_n  = 0;
    bit mon_en = 1'b0;

    twi_addr_gen #(.A_WIDTH(AW), .S_WIDTH(SW), .NUM_STAGE(NS), .PIPE_GAP(PG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .busy(busy), .valid(valid), .last(last), .done(done),
        .stage_out(stage), .MA_out(ma), .BN_out(bn), .tw_exp(tw)
    );

    twi_addr_gen #(.A_WIDTH(AW), .S_WIDTH(SW), .NUM_STAGE(NS), .PIPE_GAP(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .start(start_b), .stall(stall_b),
        .busy(busy_b), .valid(valid_b), .last(last_b), .done(done_b),
        .stage_out(stage_b), .MA_out(ma_b), .BN_out(bn_b), .tw_exp(tw_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the run is the flat word list n = s*JN + j, with each field
    // derived arithmetically from (s, j).
    function automatic int m_tw(input int s, input int j);
        int p = 1;
        for (int k = 0; k < s; k++) p = p * 16;
        return (j * p) % JN;
    endfunction

    task automatic monitor();
        int s, j;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (valid) begin
                    s = exp_n / JN;
                    j = exp_n % JN;
                    chk("word_in_range", int'(exp_n < NS * JN), 1);
                    chk("m_stage", stage, s);
                    chk("m_ma", ma, j / 2);
                    chk("m_bn", bn, $countones(j) % 2);
                    chk("m_tw", tw, m_tw(s, j));
                    chk("m_last", last, int'(j == JN - 1));
                    exp_n++;
                end else begin
                    chk("last_without_valid", last, 0);
                end
                if (done) chk("done_after_all_words", exp_n, NS * JN);
            end
        end
    endtask

    initial begin
        int words, n_last, n_gap, n_done, done_at, last_at, stall_left, cnt;
        bit gap_pulsed;
        fork monitor(); join_none

        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        rst_b = 1'b0; start_b = 1'b0; stall_b = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done_last", {done, last}, 0);
        chk("rst_data", {stage, ma, bn, tw}, 0);
        chk("rst_b_all", {busy_b, valid_b, last_b, done_b, stage_b, ma_b, bn_b, tw_b}, 0);
        @(negedge clk);
        rst_n = 1'b1; rst_b = 1'b1;
        tick();

        // Run A: no stall, full run with latency, literal words and gap counting.
        exp_n = 0; mon_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_edge1_valid", valid, 0);
        chk("lat_edge1_busy", busy, 1);
        tick();
        chk("first_valid", valid, 1);
        chk("first_word", {stage, ma, bn, tw}, 0);
        tick();
        chk("j1_ma", ma, 0);
        chk("j1_bn", bn, 1);
        chk("j1_tw", tw, 1);
        tick();
        tick();
        chk("j3_ma", ma, 1);
        chk("j3_bn", bn, 0);
        words = 4; n_last = 0; n_gap = 0; n_done = 0; done_at = -1; last_at = -1;
        for (int c = 0; c < 6000 && n_done == 0; c++) begin
            tick();
            if (valid) begin
                if (words == 1 * JN + 'h75) chk("tw_s1_j075", tw, 'h350);
                if (words == 2 * JN + 'h75) chk("tw_s2_j075", tw, 'h100);
                if (words == 3 * JN + 'h2a7) chk("tw_s3_any", tw, 0);
                if (last) n_last++;
                words++;
                last_at = c;
            end else if (busy && words < NS * JN) begin
                n_gap++;
            end
            if (done) begin
                n_done++;
                done_at = c;
                chk("busy_falls_with_done", busy, 0);
            end
        end
        chk("runA_words", words, NS * JN);
        chk("runA_gap_cycles", n_gap, (NS - 1) * PG);
        chk("runA_last_count", n_last, NS);
        chk("runA_done_count", n_done, 1);
        chk("runA_done_latency", done_at - last_at, 1);
        tick();
        chk("done_one_cycle", done, 0);

        // Run B: stall at j=100, start pulses in RUN, GAP and the DONE cycle.
        tick();
        exp_n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        words = 0; n_done = 0; stall_left = 0; gap_pulsed = 1'b0; cnt = 0;
        for (int c = 0; c < 8000 && n_done == 0; c++) begin
            tick();
            start = 1'b0;
            if (stall) begin
                cnt += int'(valid);
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end else if (valid) begin
                if (words == 100) begin
                    chk("resume_ma", ma, 50);
                    chk("resume_bn", bn, 1);
                    chk("resume_stage", stage, 0);
                end
                words++;
                if (words == 100) begin stall = 1'b1; stall_left = 10; end
                if (words == 500) start = 1'b1;
                if (words == NS * JN) start = 1'b1;
            end else if (busy && words == JN && !gap_pulsed) begin
                start = 1'b1;
                gap_pulsed = 1'b1;
            end
            if (done) n_done++;
        end
        chk("stall_valid_cycles", cnt, 0);
        chk("runB_words", words, NS * JN);
        chk("runB_done_count", n_done, 1);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            cnt += int'(valid) + int'(busy) + int'(done);
        end
        chk("start_not_queued", cnt, 0);

        // Run C: fresh start from idle, then async reset at s=2, j=500.
        exp_n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        words = 0; n_done = 0;
        for (int c = 0; c < 4000 && words < 2 * JN + 501; c++) begin
            tick();
            if (valid) words++;
            if (done) n_done++;
        end
        chk("runC_reached_s2_j500", words, 2 * JN + 501);
        chk("runC_s2_j500_word", {stage, ma}, {2'd2, 9'd250});
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {busy, valid, last, done, stage, ma, bn, tw}, 0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            cnt += int'(valid) + int'(busy) + int'(done);
            n_done += int'(done);
        end
        chk("idle_after_reset", cnt, 0);
        chk("no_done_on_reset", n_done, 0);

        // Build with no inter-stage gap: stages follow back-to-back.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        words = 0; n_gap = 0; n_done = 0; n_last = 0;
        for (int c = 0; c < 5000 && n_done == 0; c++) begin
            tick();
            if (valid_b) begin
                chk("b_stage", stage_b, words / JN);
                chk("b_ma", ma_b, (words % JN) / 2);
                if (words == JN - 1) chk("b_last_s0", last_b, 1);
                if (words == JN) chk("b_s1_first", {stage_b, ma_b, bn_b, tw_b}, {2'd1, 9'd0, 1'b0, 10'd0});
                n_last += int'(last_b);
                words++;
            end else if (busy_b && words > 0 && words < NS * JN) begin
                n_gap++;
            end
            if (done_b) n_done++;
        end
        chk("b_words", words, NS * JN);
        chk("b_gap_cycles", n_gap, 0);
        chk("b_last_count", n_last, NS);
        chk("b_done_count", n_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
